inv_park_sequencer: RTL and testbench

Control-and-datapath sequencer for the inverse Park stage of the SVPWM chain. It accepts one (d, q, theta) sample over a valid/ready handshake and fetches sin/cos from the shared sin/cos unit over a req/ack handshake. It then computes alpha = d·cos − q·sin and beta = d·sin + q·cos on a single time-shared 16×16 signed multiplier, and presents a saturated Q1.15 result to the downstream Clarke-inverse/SVPWM stage.

---
 rtl/inv_park_sequencer.sv | 150 +++++++++++++++
 tb/tb_inv_park_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_park_sequencer.sv
// Inverse Park sequencer: fetches sin/cos for one (d, q, theta) sample and computes
// alpha/beta on a single time-shared signed multiplier with round-half-up saturation.
module inv_park_sequencer #(
    parameter int unsigned SC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] d,
    input  logic [15:0] q,
    input  logic [15:0] theta,
    output logic        sc_req,
    output logic [15:0] sc_theta,
    input  logic        sc_ack,
    input  logic [15:0] sc_sin,
    input  logic [15:0] sc_cos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] alpha,
    output logic [15:0] beta,
    output logic        out_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

    localparam logic [9:0] WAIT_LAST = 10'(SC_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic signed [15:0] d_r, q_r, sin_r, cos_r;
    logic        [15:0] theta_r;
    logic        [9:0]  wait_cnt;
    logic signed [33:0] acc_a, acc_b, acc_b_fin;
    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic        [15:0] alpha_r, beta_r;
    logic               err_r;
    logic               timeout_hit;

    function automatic logic [15:0] round_sat(input logic signed [33:0] acc);
        logic signed [33:0] rnd;
        logic signed [18:0] r;
        rnd = acc + 34'sd16384;
        r   = 19'(rnd >>> 15);
        if (r > 19'sd32767)
            return 16'h7FFF;
        else if (r < -19'sd32768)
            return 16'h8000;
        else
            return r[15:0];
    endfunction

    // An ack in the expiring cycle takes precedence over the timeout.
    assign timeout_hit = !sc_ack && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = LOOKUP;
            LOOKUP:  if (sc_ack) state_nxt = MUL0;
                     else if (timeout_hit) state_nxt = DONE;
            MUL0:    state_nxt = MUL1;
            MUL1:    state_nxt = MUL2;
            MUL2:    state_nxt = MUL3;
            MUL3:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_a = d_r;
        mul_b = cos_r;
        case (state)
            MUL1:    begin mul_a = q_r; mul_b = sin_r; end
            MUL2:    begin mul_a = d_r; mul_b = sin_r; end
            MUL3:    begin mul_a = q_r; mul_b = cos_r; end
            default: begin mul_a = d_r; mul_b = cos_r; end
        endcase
    end

    assign prod      = mul_a * mul_b;
    assign acc_b_fin = acc_b + 34'(prod);

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r      <= '0;
            q_r      <= '0;
            theta_r  <= '0;
            sin_r    <= '0;
            cos_r    <= '0;
            wait_cnt <= '0;
            acc_a    <= '0;
            acc_b    <= '0;
            alpha_r  <= '0;
            beta_r   <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (in_valid) begin
                        d_r     <= d;
                        q_r     <= q;
                        theta_r <= theta;
                    end
                end
                LOOKUP: begin
                    wait_cnt <= wait_cnt + 10'd1;
                    if (sc_ack) begin
                        sin_r <= sc_sin;
                        cos_r <= sc_cos;
                    end else if (timeout_hit) begin
                        alpha_r <= '0;
                        beta_r  <= '0;
                        err_r   <= 1'b1;
                    end
                end
                MUL0: acc_a <= 34'(prod);
                MUL1: acc_a <= acc_a - 34'(prod);
                MUL2: acc_b <= 34'(prod);
                MUL3: begin
                    acc_b   <= acc_b_fin;
                    alpha_r <= round_sat(acc_a);
                    beta_r  <= round_sat(acc_b_fin);
                    err_r   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign sc_req    = (state == LOOKUP);
    assign sc_theta  = theta_r;
    assign out_valid = (state == DONE);
    assign alpha     = alpha_r;
    assign beta      = beta_r;
    assign out_err   = err_r;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_inv_park_sequencer.sv
// Self-checking bench for inv_park_sequencer: directed vector table, reset corner
// cases and randomized samples against an arithmetic reference model.
module tb_inv_park_sequencer;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [15:0] d, q, theta;
    logic        sc_req, sc_ack;
    logic [15:0] sc_theta, sc_sin, sc_cos;
    logic        out_valid, out_ready, out_err, busy;
    logic [15:0] alpha, beta;

    int n_checks = 0;
    int n_pass   = 0;

    inv_park_sequencer #(.SC_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .q(q), .theta(theta),
        .sc_req(sc_req), .sc_theta(sc_theta), .sc_ack(sc_ack),
        .sc_sin(sc_sin), .sc_cos(sc_cos),
        .out_valid(out_valid), .out_ready(out_ready),
        .alpha(alpha), .beta(beta), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d, q, th, s, c;
        int          dly;
        int          hold;
        logic [15:0] ea, eb;
        logic        ee;
        int          elat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Round half up toward +inf after scaling by 2^-15, then clamp to Q1.15.
    function automatic logic [15:0] ref_round(input longint acc);
        longint r;
        r = acc + 16384;
        if (r >= 0) r = r / 32768;
        else        r = -((-r + 32767) / 32768);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    function automatic logic [15:0] ref_alpha(input logic [15:0] rd, rq, rs, rc);
        return ref_round(longint'($signed(rd)) * $signed(rc) - longint'($signed(rq)) * $signed(rs));
    endfunction

    function automatic logic [15:0] ref_beta(input logic [15:0] rd, rq, rs, rc);
        return ref_round(longint'($signed(rd)) * $signed(rs) + longint'($signed(rq)) * $signed(rc));
    endfunction

    // One sample: accept, ack after `ack_dly` request cycles, stall the result `hold` cycles.
    task automatic do_txn(input logic [15:0] td, tq, tth, ts, tc, input int ack_dly, input int hold,
                          output logic [15:0] ra, rb, output logic re, output int lat,
                          output int nreq, output bit ok_theta, output bit ok_hold);
        int cyc;
        in_valid = 1'b1; d = td; q = tq; theta = tth;
        step();
        in_valid = 1'b0;
        d = 16'($urandom); q = 16'($urandom); theta = 16'($urandom);
        cyc = 1; nreq = 0; ok_theta = 1'b1; ok_hold = 1'b1;
        while (cyc < 60 && !out_valid) begin
            sc_ack = 1'b0;
            sc_sin = 16'($urandom); sc_cos = 16'($urandom);
            if (sc_req) begin
                if (sc_theta !== tth) ok_theta = 1'b0;
                if (nreq == ack_dly) begin
                    sc_ack = 1'b1; sc_sin = ts; sc_cos = tc;
                end
                nreq++;
            end else begin
                sc_ack = 1'($urandom);
            end
            step();
            cyc++;
        end
        lat = out_valid ? cyc : -1;
        ra = alpha; rb = beta; re = out_err;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            sc_ack = 1'b1; sc_sin = 16'($urandom); sc_cos = 16'($urandom);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || alpha !== ra || beta !== rb || out_err !== re)
                ok_hold = 1'b0;
            step();
        end
        sc_ack = 1'b0;
        out_ready = 1'b1;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || alpha !== ra || beta !== rb) ok_hold = 1'b0;
        step();
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) ok_hold = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_sc_req"}, 32'(sc_req), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_alpha"}, 32'(alpha), 32'd0);
        chk({tag, "_beta"}, 32'(beta), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[7];
        logic [15:0] ra, rb, rd, rq, rs, rc;
        logic        re;
        int          lat, nreq, dly, hold, exp_lat;
        bit          ok_th, ok_hold;

        tbl[0] = '{16'd16384, 16'd0,     16'h0000, 16'd0,     16'd32767, 0, 0, 16'd16384, 16'h0000, 1'b0, 6};
        tbl[1] = '{16'd32767, 16'h8000,  16'h1234, 16'd32767, 16'd32767, 0, 1, 16'h7FFF,  16'hFFFF, 1'b0, 6};
        tbl[2] = '{16'h8000,  16'd0,     16'hABCD, 16'd0,     16'h8000,  2, 0, 16'h7FFF,  16'h0000, 1'b0, 8};
        tbl[3] = '{16'd0,     16'd16384, 16'h4000, 16'd16384, 16'd0,     5, 3, 16'hE000,  16'h0000, 1'b0, 11};
        tbl[4] = '{16'd1,     16'd1,     16'hFFFF, 16'd1,     16'd1,     1, 0, 16'h0000,  16'h0000, 1'b0, 7};
        tbl[5] = '{16'h8000,  16'h8000,  16'h7777, 16'd32767, 16'h8000,  7, 0, 16'h7FFF,  16'h0001, 1'b0, 13};
        tbl[6] = '{16'h1111,  16'h2222,  16'h5A5A, 16'h3333,  16'h4444, 99, 2, 16'h0000,  16'h0000, 1'b1, 9};

        rst = 1'b1; in_valid = 1'b1; d = 16'h1234; q = 16'h5678; theta = 16'h9ABC;
        sc_ack = 1'b0; sc_sin = '0; sc_cos = '0; out_ready = 1'b0;
        step(); step();
        chk_reset_state("por");
        chk("por_sc_theta", 32'(sc_theta), 32'd0);
        chk("por_out_err", 32'(out_err), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].d, tbl[i].q, tbl[i].th, tbl[i].s, tbl[i].c, tbl[i].dly, tbl[i].hold,
                   ra, rb, re, lat, nreq, ok_th, ok_hold);
            chk($sformatf("vec%0d_alpha", i), 32'(ra), 32'(tbl[i].ea));
            chk($sformatf("vec%0d_beta", i), 32'(rb), 32'(tbl[i].eb));
            chk($sformatf("vec%0d_err", i), 32'(re), 32'(tbl[i].ee));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].elat));
            chk($sformatf("vec%0d_req_cycles", i), 32'(nreq), 32'((tbl[i].dly + 1 < TO) ? tbl[i].dly + 1 : TO));
            chk($sformatf("vec%0d_theta_stable", i), 32'(ok_th), 32'd1);
            chk($sformatf("vec%0d_hold", i), 32'(ok_hold), 32'd1);
        end

        // Reset in the middle of LOOKUP; in_valid during reset must not be taken.
        in_valid = 1'b1; d = 16'h0100; theta = 16'h3C3C;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("mid_lookup_req", 32'(sc_req), 32'd1);
        rst = 1'b1; in_valid = 1'b1;
        step();
        chk_reset_state("rst_lookup");
        rst = 1'b0; in_valid = 1'b0;
        step();
        chk("rst_lookup_not_accepted", 32'(busy), 32'd0);

        // Load nonzero results, then reset during MUL2.
        do_txn(16'd20000, 16'd3000, 16'h0, 16'd12000, 16'd25000, 0, 0, ra, rb, re, lat, nreq, ok_th, ok_hold);
        chk("pre_rst_alpha", 32'(ra), 32'(ref_alpha(16'd20000, 16'd3000, 16'd12000, 16'd25000)));
        in_valid = 1'b1; d = 16'd9999; q = 16'd7777;
        step();
        in_valid = 1'b0; sc_ack = 1'b1; sc_sin = 16'd5000; sc_cos = 16'd6000;
        step();
        sc_ack = 1'b0;
        step(); step();
        chk("mid_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        chk_reset_state("rst_mul2");
        rst = 1'b0;
        step();
        do_txn(16'hC000, 16'd12345, 16'h2468, 16'hF000, 16'd30000, 3, 1, ra, rb, re, lat, nreq, ok_th, ok_hold);
        chk("post_rst_alpha", 32'(ra), 32'(ref_alpha(16'hC000, 16'd12345, 16'hF000, 16'd30000)));
        chk("post_rst_beta", 32'(rb), 32'(ref_beta(16'hC000, 16'd12345, 16'hF000, 16'd30000)));
        chk("post_rst_latency", 32'(lat), 32'd9);

        // Randomized back-to-back samples against the reference model.
        for (int n = 0; n < 30; n++) begin
            rd = 16'($urandom); rq = 16'($urandom); rs = 16'($urandom); rc = 16'($urandom);
            if (n % 5 == 0) begin rd = 16'h7FFF; rq = 16'h8000; end
            dly  = $urandom_range(0, 9);
            hold = $urandom_range(0, 3);
            exp_lat = (dly < TO) ? dly + 6 : TO + 1;
            do_txn(rd, rq, 16'($urandom), rs, rc, dly, hold, ra, rb, re, lat, nreq, ok_th, ok_hold);
            chk($sformatf("rnd%0d_alpha", n), 32'(ra), 32'((dly < TO) ? ref_alpha(rd, rq, rs, rc) : 16'h0));
            chk($sformatf("rnd%0d_beta", n), 32'(rb), 32'((dly < TO) ? ref_beta(rd, rq, rs, rc) : 16'h0));
            chk($sformatf("rnd%0d_err", n), 32'(re), 32'(dly >= TO));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(exp_lat));
            chk($sformatf("rnd%0d_hold", n), 32'(ok_hold && ok_th), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
